// File: rtl/jk_drive_ctrl_pkg.sv
// Shared definitions for the JK bank drive controller.
//   DEFAULT_WIDTH     - default number of external JK flip-flops
//   DEFAULT_MAX_RETRY - default re-drive attempts after the first failed check
//   state_t           - controller FSM encoding
package jk_drive_ctrl_pkg;

    localparam int unsigned DEFAULT_WIDTH     = 4;
    localparam int unsigned DEFAULT_MAX_RETRY = 3;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StDrive  = 3'd1,
        StSettle = 3'd2,
        StCheck  = 3'd3,
        StDone   = 3'd4,
        StError  = 3'd5
    } state_t;

endpackage

// File: rtl/jk_excite.sv
// Per-bit JK excitation: sets bits that must rise, clears bits that must fall,
// holds (j=k=0) bits already at their target. Purely combinational.
//   tgt - desired bank value
//   q   - current bank value
//   j   - J inputs for the bank
//   k   - K inputs for the bank
module jk_excite
    import jk_drive_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] tgt,
    input  logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k
);

    assign j = tgt & ~q;
    assign k = ~tgt & q;

endmodule

// File: rtl/jk_drive_ctrl.sv
// Drives an external bank of JK flip-flops to a requested value, verifies the
// fed-back Q, and retries a bounded number of times before flagging an error.
//   clk, reset    - clock and synchronous active-high reset
//   start, target - request and desired bank value (sampled in IDLE only)
//   q_fb          - Q outputs fed back from the bank
//   clear         - acknowledges ERROR
//   j, k, enable  - registered drive to the bank
//   busy          - operation in progress (DRIVE/SETTLE/CHECK)
//   done          - one-cycle success pulse
//   error         - held until clear after retries are exhausted
module jk_drive_ctrl
    import jk_drive_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned MAX_RETRY = DEFAULT_MAX_RETRY
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] target,
    input  logic [WIDTH-1:0] q_fb,
    input  logic             clear,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             enable,
    output logic             busy,
    output logic             done,
    output logic             error
);

    // A zero-width counter is illegal, so MAX_RETRY=0 still gets one bit.
    localparam int unsigned CNT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [CNT_W-1:0] RETRY_LIMIT = CNT_W'(MAX_RETRY);

    state_t           state, state_n;
    logic [WIDTH-1:0] tgt_r, tgt_n;
    logic [CNT_W-1:0] retry_cnt, retry_n;
    logic [WIDTH-1:0] j_n, k_n;
    logic             enable_n;
    logic [WIDTH-1:0] exc_tgt, exc_j, exc_k;

    // On the accepting edge tgt_r is not loaded yet, so excite from target directly.
    assign exc_tgt = (state == StIdle) ? target : tgt_r;

    jk_excite #(
        .WIDTH(WIDTH)
    ) u_excite (
        .tgt(exc_tgt),
        .q  (q_fb),
        .j  (exc_j),
        .k  (exc_k)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= StIdle;
            tgt_r     <= '0;
            retry_cnt <= '0;
            j         <= '0;
            k         <= '0;
            enable    <= 1'b0;
        end else begin
            state     <= state_n;
            tgt_r     <= tgt_n;
            retry_cnt <= retry_n;
            j         <= j_n;
            k         <= k_n;
            enable    <= enable_n;
        end
    end

    always_comb begin
        state_n  = state;
        tgt_n    = tgt_r;
        retry_n  = retry_cnt;
        j_n      = '0;
        k_n      = '0;
        enable_n = 1'b0;
        unique case (state)
            StIdle: begin
                if (start) begin
                    tgt_n    = target;
                    retry_n  = '0;
                    state_n  = StDrive;
                    j_n      = exc_j;
                    k_n      = exc_k;
                    enable_n = 1'b1;
                end
            end
            StDrive:  state_n = StSettle;
            StSettle: state_n = StCheck;
            StCheck: begin
                if (q_fb == tgt_r) begin
                    state_n = StDone;
                end else if (retry_cnt < RETRY_LIMIT) begin
                    retry_n  = retry_cnt + CNT_W'(1);
                    state_n  = StDrive;
                    j_n      = exc_j;
                    k_n      = exc_k;
                    enable_n = 1'b1;
                end else begin
                    state_n = StError;
                end
            end
            StDone: state_n = StIdle;
            StError: begin
                if (clear) begin
                    state_n = StIdle;
                end
            end
            default: state_n = StIdle;
        endcase
    end

    assign busy  = (state == StDrive) || (state == StSettle) || (state == StCheck);
    assign done  = (state == StDone);
    assign error = (state == StError);

endmodule

// File: tb/tb_jk_drive_ctrl.sv
// Self-checking bench for jk_drive_ctrl with a behavioural JK bank in the loop.
module tb_jk_drive_ctrl;

    localparam int W  = 4;
    localparam int MR = 3;
    localparam int N  = 1024;

    logic         clk = 1'b0;
    logic         reset, start, clear;
    logic [W-1:0] target, q_fb, j, k, bank, stuck;
    logic         enable, busy, done, error;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jk_drive_ctrl #(
        .WIDTH    (W),
        .MAX_RETRY(MR)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .target(target),
        .q_fb  (q_fb),
        .clear (clear),
        .j     (j),
        .k     (k),
        .enable(enable),
        .busy  (busy),
        .done  (done),
        .error (error)
    );

    // External bank: plain JK flip-flops; stuck bits read back as 0.
    assign q_fb = bank & ~stuck;
    always @(posedge clk) begin
        if (reset) bank <= '0;
        else if (enable) bank <= (j & ~bank) | (~k & bank);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model: per-cycle expected timeline ----------------
    // Cycle c is the interval following rising edge c.
    logic [W-1:0] e_j [N];
    logic [W-1:0] e_k [N];
    logic [W-1:0] e_q [N];
    bit           e_en [N];
    bit           e_busy [N];
    bit           e_done [N];
    bit           e_err [N];
    int           cyc       = -1;
    bit           armed     = 1'b0;
    int           free_edge = 0;
    int           err_from  = -1;
    int           sched_end = -1;
    logic [W-1:0] model_q   = '0;

    function automatic void wipe(input int from);
        for (int i = from; i < N; i++) begin
            e_j[i] = '0; e_k[i] = '0; e_q[i] = '0;
            e_en[i] = 0; e_busy[i] = 0; e_done[i] = 0; e_err[i] = 0;
        end
    endfunction

    // Each attempt occupies three cycles; a JK drive lands every non-stuck bit on target.
    function automatic void schedule(input int c, input logic [W-1:0] t);
        logic [W-1:0] q;
        int d;
        q = model_q;
        for (int a = 0; a <= MR; a++) begin
            d = c + 3 * a;
            e_en[d] = 1; e_j[d] = t & ~q; e_k[d] = ~t & q; e_q[d] = q;
            e_busy[d] = 1; e_busy[d+1] = 1; e_busy[d+2] = 1;
            q = t & ~stuck;
            e_q[d+1] = q; e_q[d+2] = q;
            if (q == t) begin
                e_done[d+3] = 1; e_q[d+3] = q;
                sched_end = d + 3;
                free_edge = d + 5;
                break;
            end else if (a == MR) begin
                err_from  = d + 3;
                sched_end = d + 2;
            end
        end
        model_q = q;
    endfunction

    initial begin
        wipe(0);
        forever begin
            @(posedge clk);
            cyc++;
            if (cyc < N - 16) begin
                if (reset) begin
                    armed = 1; wipe(cyc);
                    err_from = -1; free_edge = cyc + 1; model_q = '0; sched_end = cyc - 1;
                end else if (armed && err_from >= 0 && cyc >= err_from) begin
                    if (cyc == err_from) e_err[cyc] = 1;
                    else if (clear) begin err_from = -1; free_edge = cyc + 1; end
                    else e_err[cyc] = 1;
                end
                if (armed && cyc > sched_end) e_q[cyc] = model_q;
                if (armed && !reset && err_from < 0 && cyc >= free_edge && start)
                    schedule(cyc, target);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (armed && cyc >= 0 && cyc < N - 16) begin
                chk($sformatf("j@%0d", cyc), 32'(j), 32'(e_j[cyc]));
                chk($sformatf("k@%0d", cyc), 32'(k), 32'(e_k[cyc]));
                chk($sformatf("enable@%0d", cyc), 32'(enable), 32'(e_en[cyc]));
                chk($sformatf("busy@%0d", cyc), 32'(busy), 32'(e_busy[cyc]));
                chk($sformatf("done@%0d", cyc), 32'(done), 32'(e_done[cyc]));
                chk($sformatf("error@%0d", cyc), 32'(error), 32'(e_err[cyc]));
                chk($sformatf("q_fb@%0d", cyc), 32'(q_fb), 32'(e_q[cyc]));
            end
        end
    end

    // ---------------- directed stimulus with literal expectations ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run_op(input string nm, input logic [W-1:0] t,
                          input logic [W-1:0] ej, input logic [W-1:0] ek);
        int n;
        start = 1; target = t;
        tick();
        start = 0; target = ~t;
        chk({nm, "_enable"}, 32'(enable), 32'd1);
        chk({nm, "_j"}, 32'(j), 32'(ej));
        chk({nm, "_k"}, 32'(k), 32'(ek));
        n = 1;
        while (!done && n < 20) begin tick(); n++; end
        chk({nm, "_latency"}, 32'(n), 32'd4);
        chk({nm, "_q"}, 32'(q_fb), 32'(t));
        tick();
        chk({nm, "_done_1cyc"}, 32'(done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        int n_drive, n;
        reset = 1; start = 0; clear = 0; target = '0; stuck = '0;
        repeat (3) tick();
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_jk", 32'({j, k, enable, done, error}), 32'd0);
        reset = 0;
        tick();

        // basic, clear/set mix, hold
        run_op("s1", 4'b1010, 4'b1010, 4'b0000);
        run_op("s2pre", 4'b1100, 4'b0100, 4'b0010);
        run_op("s2", 4'b0110, 4'b0010, 4'b1000);
        run_op("s3pre", 4'b0101, 4'b0001, 4'b0010);
        run_op("s3", 4'b0101, 4'b0000, 4'b0000);

        // start during busy is ignored
        reset = 1; tick(); tick(); reset = 0; tick();
        start = 1; target = 4'b1001;
        tick();
        chk("s6_j", 32'(j), 32'b1001);
        target = 4'b1111;
        n = 1;
        while (!done && n < 20) begin tick(); n++; end
        start = 0;
        chk("s6_latency", 32'(n), 32'd4);
        chk("s6_q", 32'(q_fb), 32'b1001);
        tick(); tick();

        // stuck bit: MAX_RETRY+1 drives, then error until clear
        reset = 1; tick(); stuck = 4'b0001; tick(); reset = 0; tick();
        start = 1; target = 4'b0001;
        tick();
        start = 0;
        n_drive = 0;
        for (int i = 0; i < 40 && !error; i++) begin
            if (enable) n_drive++;
            tick();
        end
        chk("s4_drives", 32'(n_drive), 32'd4);
        chk("s4_error", 32'(error), 32'd1);
        start = 1; target = 4'b0011;
        repeat (3) tick();
        start = 0;
        chk("s4_error_held", 32'(error), 32'd1);
        chk("s4_not_busy", 32'(busy), 32'd0);
        clear = 1; start = 1; target = 4'b1111;
        tick();
        clear = 0; start = 0;
        chk("s4_cleared", 32'(error), 32'd0);
        chk("s4_no_start", 32'(busy), 32'd0);
        tick();
        chk("s4_idle_en", 32'(enable), 32'd0);
        chk("s4_idle_busy", 32'(busy), 32'd0);
        reset = 1; tick(); stuck = '0; tick(); reset = 0; tick();

        // reset in SETTLE
        start = 1; target = 4'b0011;
        tick();
        start = 0;
        tick();
        chk("s5_in_settle", 32'(busy), 32'd1);
        reset = 1;
        tick();
        reset = 0;
        chk("s5_outputs", 32'({j, k, enable, busy, done, error}), 32'd0);
        chk("s5_bank", 32'(q_fb), 32'd0);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (done || error) n++;
            tick();
        end
        chk("s5_no_pulse", 32'(n), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jk_drive_ctrl.md
JK_DRIVE_CTRL -- requirements
Module: jk_drive_ctrl

Interface
REQ-001 Parameter WIDTH, default 4: number of external JK flip-flops driven.
REQ-002 Parameter MAX_RETRY, default 3: re-drive attempts allowed after the first failed check.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  reset is synchronous and active-high.
REQ-005 start  input  1  request to move the external bank to target; sampled only in IDLE.
REQ-006 target  input  WIDTH  desired bank value; latched on accepted start.
REQ-007 q_fb  input  WIDTH  Q outputs fed back from the external JK bank.
REQ-008 clear  input  1  acknowledges ERROR; ignored in every other state.
REQ-009 j  output  WIDTH  registered J drive to the bank.
REQ-010 k  output  WIDTH  registered K drive to the bank.
REQ-011 enable  output  1  registered enable to the bank; high only in DRIVE.
REQ-012 busy  output  1  high in DRIVE, SETTLE and CHECK.
REQ-013 done  output  1  one-cycle success pulse; high only in DONE.
REQ-014 error  output  1  high only in ERROR.

Function
REQ-015 The FSM SHALL have states IDLE, DRIVE, SETTLE, CHECK, DONE and ERROR.
REQ-016 IDLE with start=1: latch target into tgt_r, clear retry_cnt, go to DRIVE. With start=0, stay.
REQ-017 On every entry to DRIVE, per bit: j <= tgt_r & ~q_fb; k <= ~tgt_r & q_fb; enable <= 1. Bits already equal get j=k=0 (hold).
REQ-018 DRIVE lasts exactly one cycle, then SETTLE. On leaving DRIVE: j, k and enable <= 0.
REQ-019 SETTLE lasts exactly one cycle, then CHECK; it lets q_fb reflect the bank update.
REQ-020 CHECK with q_fb == tgt_r: go to DONE.
REQ-021 CHECK with mismatch and retry_cnt < MAX_RETRY: increment retry_cnt and re-enter DRIVE. J and K are recomputed from the current q_fb.
REQ-022 CHECK with mismatch and retry_cnt == MAX_RETRY: go to ERROR. Total attempts = MAX_RETRY+1.
REQ-023 DONE lasts one cycle, then IDLE. start during DONE is ignored.
REQ-024 ERROR holds until clear=1, then goes to IDLE. start is ignored in ERROR, including when it arrives in the same cycle as clear.
REQ-025 start, target and clear are ignored in DRIVE, SETTLE and CHECK. tgt_r is stable for the whole operation.
REQ-026 Latency, no retries: start accepted at edge N; DRIVE cycle N+1; SETTLE N+2; CHECK N+3; done high in cycle N+4.
REQ-027 target equal to q_fb at start: still runs the full sequence with j=k=0 and reports done.
REQ-028 retry_cnt width SHALL be clog2(MAX_RETRY+1) and SHALL never wrap.

Reset
REQ-029 When reset=1 at a rising edge, the block SHALL enter IDLE. All of the following are 0: j, k, enable, busy, done, error, tgt_r and retry_cnt.
REQ-030 reset overrides all other inputs in every state, including mid-operation. No done or error pulse follows a reset.

Structure
REQ-031 A shared package SHALL hold the state encoding constants and default values for WIDTH and MAX_RETRY.
REQ-032 A sub-module jk_excite SHALL compute per-bit J/K from tgt_r and q_fb. It is purely combinational and instantiated WIDTH times, or once as a vector.
REQ-033 The FSM, registers and output decoding SHALL reside in jk_drive_ctrl. Outputs are registered or decoded from state only.

Verification
REQ-034 Bench model: the bank SHALL be WIDTH JK flip-flops sharing the same clk and reset, driven by j, k and enable, with Q fed back to q_fb.
REQ-035 Scenario 1, basic: q_fb=0000, start with target=1010. Required: in DRIVE, j=1010, k=0000, enable=1; done high exactly 4 cycles after accept; q_fb=1010.
REQ-036 Scenario 2, clear and set mix: bank at 1100, target 0110. Required: j=0010, k=1000; then done with q_fb=0110.
REQ-037 Scenario 3, hold: bank at 0101, target 0101. Required: j=k=0000 with enable=1 in DRIVE; done asserted; q_fb unchanged.
REQ-038 Scenario 4, stuck bit: force q_fb[0]=0, target 0001. Required: 4 DRIVE cycles, then error=1 held. clear with simultaneous start returns to IDLE; no new operation starts.
REQ-039 Scenario 5, reset mid-operation: assert reset in SETTLE. Required: next cycle is IDLE with all outputs 0, and no done pulse follows.
REQ-040 Scenario 6, busy ignore: start with target=1111 during busy. Required: ignored; the operation completes to the original tgt_r.
